// File: rtl/gb_cpu_alu16_seq.sv
// gb_cpu_alu16_seq: 16-bit ALU group (ADD HL,rr / ADD SP,e8 / INC rr / DEC rr)
// executed as two chained 8-bit passes, low byte then high byte.
module gb_cpu_alu16_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [15:0] operand_a_i,
  input  logic [15:0] operand_b_i,
  input  logic [3:0]  flags_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] result_o,
  output logic [3:0]  flags_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOW  = 2'b01,
    S_HIGH = 2'b10,
    S_DONE = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD16 = 2'b00,
    OP_ADDSP = 2'b01,
    OP_INC16 = 2'b10,
    OP_DEC16 = 2'b11
  } op_t;

  state_t      state_q;
  op_t         op_q;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [3:0]  flags_in_q;
  logic [7:0]  res_lo_q;
  logic        c8_q;
  logic        h4_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] result_q;
  logic [3:0]  flags_q;

  logic [7:0]  b_lo;
  logic [7:0]  b_hi;
  logic [8:0]  sum_lo_d;
  logic [4:0]  nib_lo_d;
  logic [8:0]  sum_hi_d;
  logic [4:0]  nib_hi_d;
  logic [3:0]  flags_d;
  logic        accept;

  // Per-op operand bytes, the two 8-bit adds and the resulting flags
  always_comb begin
    b_lo = b_q[7:0];
    b_hi = b_q[15:8];
    unique case (op_q)
      OP_ADD16: begin b_lo = b_q[7:0]; b_hi = b_q[15:8];   end
      OP_ADDSP: begin b_lo = b_q[7:0]; b_hi = {8{b_q[7]}}; end
      OP_INC16: begin b_lo = 8'h01;    b_hi = 8'h00;       end
      OP_DEC16: begin b_lo = 8'hFF;    b_hi = 8'hFF;       end
    endcase
    sum_lo_d = {1'b0, a_q[7:0]} + {1'b0, b_lo};
    nib_lo_d = {1'b0, a_q[3:0]} + {1'b0, b_lo[3:0]};
    sum_hi_d = {1'b0, a_q[15:8]} + {1'b0, b_hi} + {8'h00, c8_q};
    nib_hi_d = {1'b0, a_q[11:8]} + {1'b0, b_hi[3:0]} + {4'h0, c8_q};
    unique case (op_q)
      OP_ADD16: flags_d = {flags_in_q[3], 1'b0, nib_hi_d[4], sum_hi_d[8]};
      OP_ADDSP: flags_d = {2'b00, h4_q, c8_q};
      default:  flags_d = flags_in_q;
    endcase
  end

  assign accept = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Sequencer: accept request, low pass, high pass, publish result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= OP_ADD16;
      a_q        <= '0;
      b_q        <= '0;
      flags_in_q <= '0;
      res_lo_q   <= '0;
      c8_q       <= 1'b0;
      h4_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      flags_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            op_q       <= op_t'(op_i);
            a_q        <= operand_a_i;
            b_q        <= operand_b_i;
            flags_in_q <= flags_i;
            busy_q     <= 1'b1;
            state_q    <= S_LOW;
          end else begin
            busy_q     <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
        S_LOW: begin
          res_lo_q <= sum_lo_d[7:0];
          c8_q     <= sum_lo_d[8];
          h4_q     <= nib_lo_d[4];
          state_q  <= S_HIGH;
        end
        S_HIGH: begin
          result_q <= {sum_hi_d[7:0], res_lo_q};
          flags_q  <= flags_d;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= S_DONE;
        end
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign flags_o  = flags_q;

endmodule
